// File: rtl/transmitter.sv
// UART transmitter: one-deep holding buffer feeding a baud_tick-paced start/data/stop framer.
// Define UART_TX_PARITY_EN to insert an even parity bit between data bit 7 and the stop bit(s).
module transmitter #(
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_e;
`endif

  // Index of the final stop interval: 0 for one stop bit, 1 for two.
  localparam logic STOP_LAST = (STOP_BITS == 2);

  state_e     state_q, state_d;
  logic [7:0] buf_q, buf_d;
  logic       buf_full_q, buf_full_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic       tx_out_q, tx_out_d;
  logic       tx_done_q, tx_done_d;
  logic       load;
`ifdef UART_TX_PARITY_EN
  logic       parity_q, parity_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_out_q   <= tx_out_d;
      tx_done_q  <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_out_d   = tx_out_q;
    tx_done_d  = 1'b0;
    load       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (baud_tick) begin
          tx_out_d = 1'b1;
          load     = buf_full_q;
        end
      end
      START: begin
        if (baud_tick) begin
          tx_out_d  = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q != 3'd7) begin
            tx_out_d  = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else begin
`ifdef UART_TX_PARITY_EN
            tx_out_d   = parity_q;
            state_d    = PARITY;
`else
            tx_out_d   = 1'b1;
            state_d    = STOP;
            stop_cnt_d = 1'b0;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          tx_out_d   = 1'b1;
          state_d    = STOP;
          stop_cnt_d = 1'b0;
        end
      end
`endif
      STOP: begin
        if (baud_tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            tx_done_d = 1'b1;
            load      = buf_full_q;
            if (!buf_full_q) begin
              state_d  = IDLE;
              tx_out_d = 1'b1;
            end
          end else begin
            stop_cnt_d = 1'b1;
            tx_out_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        tx_out_d = 1'b1;
      end
    endcase

    // Shared by IDLE and the final stop tick so back-to-back frames need no idle bit.
    if (load) begin
      shift_d    = buf_q;
      buf_full_d = 1'b0;
      tx_out_d   = 1'b0;
      bit_cnt_d  = '0;
      state_d    = START;
`ifdef UART_TX_PARITY_EN
      parity_d   = ^buf_q;
`endif
    end

    // Load needs a full buffer and acceptance an empty one, so the two never collide.
    if (tx_data_valid && !buf_full_q) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end
  end

  always_comb begin
    tx_ready = !buf_full_q;
    tx_out   = tx_out_q;
    tx_busy  = (state_q != IDLE);
    tx_done  = tx_done_q;
  end

endmodule

// File: tb/tb_transmitter.sv
// Self-checking bench for transmitter: line samples per baud tick are decoded by a
// receiver-style reference model and compared against the bytes offered.
module tb_transmitter;
  localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef logic       bitq_t[$];
  typedef logic [7:0] byteq_t[$];

  logic       clk;
  logic       rst_n;
  logic       baud_tick;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       rdy1, out1, busy1, done1;
  logic       rdy2, out2, busy2, done2;

  int    total  = 0;
  int    passed = 0;
  bitq_t line1, line2;
  int    done1_idx[$];
  int    done2_idx[$];
  int    busy1_cyc, busy2_cyc;

  transmitter #(.STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_data_valid(tx_data_valid), .tx_ready(rdy1), .tx_out(out1),
    .tx_busy(busy1), .tx_done(done1)
  );

  transmitter #(.STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_data_valid(tx_data_valid), .tx_ready(rdy2), .tx_out(out2),
    .tx_busy(busy2), .tx_done(done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin : baud_gen
    int cnt;
    cnt = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (cnt == DIV - 1) begin
        baud_tick = 1'b1;
        cnt = 0;
      end else begin
        baud_tick = 1'b0;
        cnt++;
      end
    end
  end

  // One line sample per tick edge; tx_done is tagged with the sample index of its edge.
  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (baud_tick === 1'b1) begin
        line1.push_back(out1);
        line2.push_back(out2);
      end
      if (done1 === 1'b1) done1_idx.push_back(line1.size() - 1);
      if (done2 === 1'b1) done2_idx.push_back(line2.size() - 1);
      if (busy1 === 1'b1) busy1_cyc++;
      if (busy2 === 1'b1) busy2_cyc++;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time=%0t required_finish_before=1000000", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic bitq_t frame_of(input logic [7:0] b, input int sb);
    bitq_t q;
    int ones;
    ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      q.push_back(b[i]);
      ones += int'(b[i]);
    end
    if (PAR == 1) q.push_back((ones % 2) == 1);
    for (int i = 0; i < sb; i++) q.push_back(1'b1);
    return q;
  endfunction

  function automatic byteq_t decode(input bitq_t line, input int sb, output int errs);
    byteq_t r;
    logic [7:0] b;
    int i, ones;
    errs = 0;
    i = 0;
    while (i < line.size()) begin
      if (line[i] === 1'b1) begin
        i++;
      end else if (line[i] !== 1'b0) begin
        errs++;
        i++;
      end else if (i + 9 + PAR + sb > line.size()) begin
        errs++;
        i = line.size();
      end else begin
        ones = 0;
        for (int k = 0; k < 8; k++) begin
          b[k] = line[i + 1 + k];
          ones += (line[i + 1 + k] === 1'b1) ? 1 : 0;
        end
        if (PAR == 1 && line[i + 9] !== ((ones % 2) == 1)) errs++;
        for (int k = 0; k < sb; k++)
          if (line[i + 9 + PAR + k] !== 1'b1) errs++;
        r.push_back(b);
        i += 9 + PAR + sb;
      end
    end
    return r;
  endfunction

  function automatic int first_zero(input bitq_t q);
    for (int i = 0; i < q.size(); i++)
      if (q[i] === 1'b0) return i;
    return -1;
  endfunction

  function automatic int count_diff(input bitq_t q, input int s, input bitq_t exp);
    int d;
    d = 0;
    if (s < 0) return exp.size();
    for (int i = 0; i < exp.size(); i++)
      if (s + i >= q.size() || q[s + i] !== exp[i]) d++;
    return d;
  endfunction

  function automatic int count_non_idle(input bitq_t q, input int from);
    int d;
    d = 0;
    for (int i = (from < 0 ? 0 : from); i < q.size(); i++)
      if (q[i] !== 1'b1) d++;
    return d;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_mon();
    line1.delete();
    line2.delete();
    done1_idx.delete();
    done2_idx.delete();
    busy1_cyc = 0;
    busy2_cyc = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tx_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!(rdy1 && rdy2) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 5000) $display("FAIL send_wait: ready1=%b ready2=%b required=1,1", rdy1, rdy2);
    else passed++;
    tx_data = b;
    tx_data_valid = 1'b1;
    @(negedge clk);
    tx_data_valid = 1'b0;
    tx_data = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n, quiet;
    n = 0;
    quiet = 0;
    while (quiet < 3 * DIV && n < 5000) begin
      @(negedge clk);
      n++;
      if (!busy1 && rdy1 && !busy2 && rdy2) quiet++;
      else quiet = 0;
    end
    repeat (2 * DIV) @(negedge clk);
    total++;
    if (n >= 5000) $display("FAIL idle_wait: busy1=%b busy2=%b required=0,0", busy1, busy2);
    else passed++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({out1, rdy1, busy1, done1} !== 4'b1100)
      $display("FAIL reset_dut1: out/ready/busy/done=%b required=1100", {out1, rdy1, busy1, done1});
    else passed++;
    total++;
    if ({out2, rdy2, busy2, done2} !== 4'b1100)
      $display("FAIL reset_dut2: out/ready/busy/done=%b required=1100", {out2, rdy2, busy2, done2});
    else passed++;
    rst_n = 1'b1;
    clear_mon();
    repeat (5 * DIV) @(negedge clk);
    total++;
    if (count_non_idle(line1, 0) + count_non_idle(line2, 0) + done1_idx.size() + done2_idx.size() != 0)
      $display("FAIL reset_idle: non_idle=%0d dones=%0d required=0,0",
               count_non_idle(line1, 0) + count_non_idle(line2, 0), done1_idx.size() + done2_idx.size());
    else passed++;
  endtask

  task automatic test_frame(input logic [7:0] b);
    bitq_t exp;
    int s, n, d, pos;
    do_reset();
    send_byte(b);
    wait_idle();
    exp = frame_of(b, 1);
    n = exp.size();
    s = first_zero(line1);
    d = count_diff(line1, s, exp);
    total++;
    if (d != 0) $display("FAIL frame_%h: differing_bits=%0d start=%0d required=0", b, d, s);
    else passed++;
    d = count_non_idle(line1, s + n);
    total++;
    if (d != 0) $display("FAIL frame_%h_tail: non_idle=%0d required=0", b, d);
    else passed++;
    total++;
    if (done1_idx.size() != 1) $display("FAIL frame_%h_done_count: got=%0d required=1", b, done1_idx.size());
    else passed++;
    pos = (done1_idx.size() > 0) ? done1_idx[0] : -1;
    total++;
    if (pos != s + n) $display("FAIL frame_%h_done_pos: got=%0d required=%0d", b, pos, s + n);
    else passed++;
    total++;
    if (busy1_cyc != n * DIV) $display("FAIL frame_%h_busy: cycles=%0d required=%0d", b, busy1_cyc, n * DIV);
    else passed++;
  endtask

  task automatic test_back_to_back();
    byteq_t seq;
    bitq_t exp, f;
    int s, d;
    logic r, bsy;
    seq = '{8'h55, 8'h0F, 8'h3C};
    do_reset();
    @(negedge clk);
    tx_data_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int waited;
      logic took;
      waited = 0;
      took = 1'b0;
      bsy = 1'b0;
      tx_data = seq[k];
      while (!took && waited < 2000) begin
        r = rdy1;
        bsy = busy1;
        @(posedge clk);
        took = r;
        @(negedge clk);
        waited++;
      end
      total++;
      if (!took) $display("FAIL b2b_accept_%0d: accepted=0 required=1", k);
      else passed++;
      if (k == 1) begin
        total++;
        if (bsy !== 1'b1) $display("FAIL b2b_second_during_frame: busy=%b required=1", bsy);
        else passed++;
      end
      if (k == 2) begin
        total++;
        if (done1_idx.size() != 1)
          $display("FAIL b2b_third_after_load: frames_done=%0d required=1", done1_idx.size());
        else passed++;
      end
    end
    tx_data_valid = 1'b0;
    tx_data = 8'($urandom);
    wait_idle();
    for (int k = 0; k < 3; k++) begin
      f = frame_of(seq[k], 1);
      foreach (f[i]) exp.push_back(f[i]);
    end
    s = first_zero(line1);
    d = count_diff(line1, s, exp) + count_non_idle(line1, s + exp.size());
    total++;
    if (d != 0) $display("FAIL b2b_line: differing_bits=%0d required=0", d);
    else passed++;
    total++;
    if (done1_idx.size() != 3) $display("FAIL b2b_done_count: got=%0d required=3", done1_idx.size());
    else passed++;
  endtask

  task automatic test_reset_midframe();
    byteq_t dec;
    int errs, s, n;
    logic [7:0] got;
    do_reset();
    send_byte(8'hFF);
    send_byte(8'h77);
    n = 0;
    s = first_zero(line1);
    while ((s < 0 || line1.size() < s + 6) && n < 2000) begin
      @(negedge clk);
      n++;
      s = first_zero(line1);
    end
    total++;
    if (n >= 2000) $display("FAIL midframe_reach_bit4: samples=%0d required>=%0d", line1.size(), s + 6);
    else passed++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({out1, rdy1, busy1, done1} !== 4'b1100)
      $display("FAIL midframe_reset_outputs: out/ready/busy/done=%b required=1100", {out1, rdy1, busy1, done1});
    else passed++;
    repeat (3 * DIV) @(negedge clk);
    total++;
    if (done1_idx.size() != 0) $display("FAIL midframe_no_done: dones=%0d required=0", done1_idx.size());
    else passed++;
    rst_n = 1'b1;
    clear_mon();
    send_byte(8'h81);
    wait_idle();
    dec = decode(line1, 1, errs);
    total++;
    if (dec.size() != 1) $display("FAIL midframe_frames: got=%0d required=1", dec.size());
    else passed++;
    got = (dec.size() > 0) ? dec[0] : 8'hxx;
    total++;
    if (got !== 8'h81) $display("FAIL midframe_byte: got=%h required=81", got);
    else passed++;
    total++;
    if (errs != 0) $display("FAIL midframe_framing: errors=%0d required=0", errs);
    else passed++;
  endtask

  task automatic test_stop2();
    bitq_t exp;
    int s, n, d, pos;
    do_reset();
    send_byte(8'h00);
    wait_idle();
    exp = frame_of(8'h00, 2);
    n = exp.size();
    s = first_zero(line2);
    d = count_diff(line2, s, exp) + count_non_idle(line2, s + n);
    total++;
    if (d != 0) $display("FAIL stop2_line: differing_bits=%0d required=0", d);
    else passed++;
    total++;
    if (done2_idx.size() != 1) $display("FAIL stop2_done_count: got=%0d required=1", done2_idx.size());
    else passed++;
    pos = (done2_idx.size() > 0) ? done2_idx[0] : -1;
    total++;
    if (pos != s + n) $display("FAIL stop2_done_pos: got=%0d required=%0d", pos, s + n);
    else passed++;
    total++;
    if (busy2_cyc != n * DIV) $display("FAIL stop2_busy: cycles=%0d required=%0d", busy2_cyc, n * DIV);
    else passed++;
  endtask

  task automatic test_random();
    byteq_t exp_b, dec1, dec2;
    int errs1, errs2;
    logic [7:0] b, g1, g2;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      exp_b.push_back(b);
      send_byte(b);
      repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    wait_idle();
    dec1 = decode(line1, 1, errs1);
    dec2 = decode(line2, 2, errs2);
    total++;
    if (dec1.size() != 8 || dec2.size() != 8)
      $display("FAIL rand_frames: got=%0d,%0d required=8,8", dec1.size(), dec2.size());
    else passed++;
    for (int i = 0; i < exp_b.size(); i++) begin
      g1 = (i < dec1.size()) ? dec1[i] : 8'hxx;
      g2 = (i < dec2.size()) ? dec2[i] : 8'hxx;
      total++;
      if (g1 !== exp_b[i] || g2 !== exp_b[i])
        $display("FAIL rand_byte_%0d: got=%h,%h required=%h", i, g1, g2, exp_b[i]);
      else passed++;
    end
    total++;
    if (errs1 + errs2 != 0) $display("FAIL rand_framing: errors=%0d,%0d required=0,0", errs1, errs2);
    else passed++;
    total++;
    if (done1_idx.size() != 8 || done2_idx.size() != 8)
      $display("FAIL rand_done_count: got=%0d,%0d required=8,8", done1_idx.size(), done2_idx.size());
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    tx_data_valid = 1'b0;
    tx_data = '0;
    test_reset();
    test_frame(8'hA5);
    test_frame(8'h01);
    test_back_to_back();
    test_reset_midframe();
    test_stop2();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/transmitter.md
TRANSMITTER -- requirements
Module: transmitter

Interface
REQ-001 The block SHALL have parameter STOP_BITS, default 1, number of stop bits per frame; legal values are 1 and 2.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL be on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port baud_tick, input, 1 bit, a one-clk pulse per bit period.
REQ-005 The block SHALL have port tx_data, input, 8 bits, the byte to send, LSB first.
REQ-006 The block SHALL have port tx_data_valid, input, 1 bit, tx_data is valid.
REQ-007 The block SHALL have port tx_ready, output, 1 bit, high when the holding buffer is empty.
REQ-008 The block SHALL have port tx_out, output, 1 bit, the registered serial line, idle high.
REQ-009 The block SHALL have port tx_busy, output, 1 bit, high when state is not IDLE.
REQ-010 The block SHALL have port tx_done, output, 1 bit, a one-clk pulse at frame completion.

Function
REQ-011 A byte SHALL transfer on any clk edge where tx_data_valid=1 and tx_ready=1, independent of baud_tick; it is captured into a one-deep holding buffer.
REQ-012 tx_ready SHALL equal NOT buffer_full; it SHALL drop the cycle after an acceptance and rise the cycle after the buffer loads into the shift register.
REQ-013 The state machine SHALL have states IDLE, START, DATA, PARITY and STOP; transitions and tx_out changes SHALL occur only on edges with baud_tick=1.
REQ-014 IDLE: on a tick with buffer_full=1, the block SHALL load the shift register, clear the buffer, drive tx_out=0 and go to START; otherwise tx_out SHALL be 1.
REQ-015 A byte accepted on the same edge as an IDLE tick SHALL NOT load on that edge; it SHALL load on the next tick.
REQ-016 START: on a tick, tx_out SHALL take data[0], bit_cnt SHALL be 0 and the state SHALL go to DATA.
REQ-017 DATA: on a tick with bit_cnt<7, tx_out SHALL take data[bit_cnt+1] and bit_cnt SHALL increment; with bit_cnt=7, the state SHALL go to PARITY (driving the parity bit) when parity is enabled, otherwise to STOP (driving 1).
REQ-018 PARITY: on a tick, tx_out SHALL be 1 and the state SHALL go to STOP.
REQ-019 STOP SHALL last STOP_BITS tick intervals; on its final tick tx_done SHALL pulse for exactly one clk.
REQ-020 On that same final tick, if buffer_full=1 the block SHALL perform the IDLE load action (tx_out=0, START) with no idle bit between frames; otherwise it SHALL go to IDLE with tx_out=1.
REQ-021 Each bit SHALL be held on tx_out for exactly one tick interval; a frame SHALL be 10, 11 or 12 bit times.
REQ-022 tx_data changes while the byte is in the buffer or shift register SHALL NOT affect the frame.
REQ-023 Illegal state encodings SHALL recover to IDLE with tx_out=1.

Reset
REQ-024 While rst_n=0, the outputs SHALL be: tx_out=1, tx_ready=1, tx_busy=0, tx_done=0; the state SHALL be IDLE, the buffer SHALL be empty, and the counters and shift register SHALL be 0.
REQ-025 Reset mid-frame SHALL abort the frame immediately (tx_out high asynchronously), discard buffered data and produce no tx_done.

Configuration
REQ-026 With macro UART_TX_PARITY_EN defined, the block SHALL insert an even parity bit (XOR of the 8 data bits) after bit 7 via the PARITY state; without it, the PARITY state and its logic SHALL be absent and DATA SHALL go directly to STOP.

Verification
REQ-027 The bench SHALL send 0xA5 with no parity and STOP_BITS=1; tx_out per tick SHALL be 0,1,0,1,0,0,1,0,1,1, with tx_done pulsed once and tx_busy high for 10 bit times.
REQ-028 The bench SHALL send 0xA5 with UART_TX_PARITY_EN defined; the parity bit SHALL be 0, the frame SHALL be 11 bits, and the same with 0x01 SHALL give parity 1.
REQ-029 The bench SHALL offer 0x55 then 0x0F while tx_data_valid is held high; the second byte SHALL be accepted during frame 1, and its start bit SHALL follow frame 1's stop bit with no idle gap.
REQ-030 The bench SHALL offer a third byte 0x3C while the buffer is full; tx_ready SHALL stay 0 until the 0x0F load, and 0x3C SHALL transmit third and uncorrupted.
REQ-031 The bench SHALL assert rst_n=0 during data bit 4 of 0xFF; tx_out SHALL be 1 immediately with no tx_done, and after release a new byte 0x81 SHALL transmit correctly.
REQ-032 The bench SHALL send 0x00 with STOP_BITS=2; there SHALL be 2 stop-bit intervals and tx_done SHALL pulse only on the second stop tick.
